// File: rtl/data_mem_access_ctrl_if.sv
// rtl/data_mem_access_ctrl_if.sv - CPU request, memory and response signals of the data memory access controller
interface data_mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misalign_err;
  logic        timeout_err;
  logic        busy;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output rsp_valid, rsp_rdata, misalign_err, timeout_err, busy
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  rsp_valid, rsp_rdata, misalign_err, timeout_err, busy
  );
endinterface

// File: rtl/data_mem_access_ctrl.sv
// rtl/data_mem_access_ctrl.sv - load/store sequencer: alignment check, byte lanes, load extension, ack timeout
module data_mem_access_ctrl (
  input logic                  clk,
  input logic                  rst,
  data_mem_access_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_ILL  = 2'b10;
  localparam logic [1:0] SZ_HALF = 2'b11;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;
  logic        timeout_q, timeout_d;

  logic        req_misalign;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic [3:0]  be_raw;
  logic [31:0] wdata_raw;
  logic        in_access;
  logic        in_resp;

  assign req_misalign = (bus.req_size == SZ_ILL) ||
                        (bus.req_size == SZ_HALF && bus.req_addr[0]) ||
                        (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00);

  always_comb begin
    byte_lane = 8'h00;
    case (addr_q[1:0])
      2'd0:    byte_lane = bus.mem_rdata[7:0];
      2'd1:    byte_lane = bus.mem_rdata[15:8];
      2'd2:    byte_lane = bus.mem_rdata[23:16];
      default: byte_lane = bus.mem_rdata[31:24];
    endcase
    half_lane = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    load_data = bus.mem_rdata;
    case (size_q)
      SZ_BYTE: load_data = unsigned_q ? {24'h000000, byte_lane}
                                      : {{24{byte_lane[7]}}, byte_lane};
      SZ_HALF: load_data = unsigned_q ? {16'h0000, half_lane}
                                      : {{16{half_lane[15]}}, half_lane};
      default: load_data = bus.mem_rdata;
    endcase
  end

  always_comb begin
    be_raw    = 4'b1111;
    wdata_raw = wdata_q;
    case (size_q)
      SZ_BYTE: begin
        be_raw    = 4'b0001 << addr_q[1:0];
        wdata_raw = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        be_raw    = 4'b0011 << addr_q[1:0];
        wdata_raw = {2{wdata_q[15:0]}};
      end
      default: begin
        be_raw    = 4'b1111;
        wdata_raw = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wait_d     = wait_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d       = bus.req_we;
          size_d     = bus.req_size;
          unsigned_d = bus.req_unsigned;
          addr_d     = bus.req_addr;
          wdata_d    = bus.req_wdata;
          wait_d     = 8'h00;
          rdata_d    = 32'h0;
          timeout_d  = 1'b0;
          misalign_d = req_misalign;
          state_d    = req_misalign ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // An ack in the final wait cycle takes priority over the timeout.
        if (bus.mem_ack) begin
          rdata_d = we_q ? 32'h0 : load_data;
          state_d = ST_RESP;
        end else if (wait_q == 8'hFF) begin
          timeout_d = 1'b1;
          rdata_d   = 32'h0;
          state_d   = ST_RESP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_RESP: begin
        misalign_d = 1'b0;
        timeout_d  = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wait_q     <= 8'h00;
      rdata_q    <= 32'h0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wait_q     <= wait_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
  end

  assign in_access = (state_q == ST_ACCESS);
  assign in_resp   = (state_q == ST_RESP);

  // Memory-side and response outputs are forced to zero outside their owning state.
  assign bus.req_ready    = (state_q == ST_IDLE);
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.mem_req      = in_access;
  assign bus.mem_we       = in_access & we_q;
  assign bus.mem_addr     = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.mem_be       = in_access ? be_raw : 4'b0000;
  assign bus.mem_wdata    = in_access ? wdata_raw : 32'h0;
  assign bus.rsp_valid    = in_resp;
  assign bus.rsp_rdata    = in_resp ? rdata_q : 32'h0;
  assign bus.misalign_err = in_resp & misalign_q;
  assign bus.timeout_err  = in_resp & timeout_q;

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// tb/tb_data_mem_access_ctrl.sv - directed self-checking bench for data_mem_access_ctrl
module tb_data_mem_access_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  data_mem_access_ctrl_if bus ();

  data_mem_access_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Presents one request at the current negedge; returns at the next negedge.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(negedge clk);
    bus.req_valid    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.mem_req, bus.mem_we, bus.rsp_valid, bus.misalign_err, bus.timeout_err, bus.busy, bus.req_ready} !== 7'b0000001) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000001",
               {bus.mem_req, bus.mem_we, bus.rsp_valid, bus.misalign_err, bus.timeout_err, bus.busy, bus.req_ready});
    end
    n_checks++;
    if ({bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.rsp_rdata} !== 100'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h %h want zeros", bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.rsp_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_ready: got ready=%b busy=%b want 1 0", bus.req_ready, bus.busy);
    end
  endtask

  task automatic test_byte_store();
    issue(1'b1, 2'b01, 1'b0, 32'h0000_1003, 32'h0000_00A5);
    n_checks++;
    if ({bus.mem_req, bus.mem_we, bus.busy, bus.req_ready} !== 4'b1110) begin
      n_fail++;
      $display("FAIL bstore_ctrl: got %b want 1110", {bus.mem_req, bus.mem_we, bus.busy, bus.req_ready});
    end
    n_checks++;
    if (bus.mem_addr !== 32'h0000_1000) begin
      n_fail++;
      $display("FAIL bstore_addr: got %h want 00001000", bus.mem_addr);
    end
    n_checks++;
    if (bus.mem_be !== 4'b1000) begin
      n_fail++;
      $display("FAIL bstore_be: got %b want 1000", bus.mem_be);
    end
    n_checks++;
    if (bus.mem_wdata !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL bstore_wdata: got %h want a5a5a5a5", bus.mem_wdata);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    n_checks++;
    if ({bus.rsp_valid, bus.mem_req, bus.misalign_err, bus.timeout_err} !== 4'b1000 || bus.rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL bstore_rsp: got v/req/me/te=%b rdata=%h want 1000 00000000",
               {bus.rsp_valid, bus.mem_req, bus.misalign_err, bus.timeout_err}, bus.rsp_rdata);
    end
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bstore_done: got valid=%b ready=%b want 0 1", bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_halfword_load();
    logic [31:0] exp_rdata [2];
    exp_rdata[0] = 32'hFFFF_8001;
    exp_rdata[1] = 32'h0000_8001;
    for (int u = 0; u < 2; u++) begin
      issue(1'b0, 2'b11, u[0], 32'h0000_2002, 32'h0);
      n_checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'b1100 || bus.mem_addr !== 32'h0000_2000) begin
        n_fail++;
        $display("FAIL hload_req[%0d]: got req=%b we=%b be=%b addr=%h want 1 0 1100 00002000",
                 u, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr);
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h8001_1234;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp_rdata[u]) begin
        n_fail++;
        $display("FAIL hload_rsp[%0d]: got valid=%b rdata=%h want 1 %h", u, bus.rsp_valid, bus.rsp_rdata, exp_rdata[u]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_byte_load();
    issue(1'b0, 2'b01, 1'b0, 32'h0000_4001, 32'h0);
    n_checks++;
    if (bus.mem_be !== 4'b0010 || bus.mem_addr !== 32'h0000_4000) begin
      n_fail++;
      $display("FAIL bload_req: got be=%b addr=%h want 0010 00004000", bus.mem_be, bus.mem_addr);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_8056;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hFFFF_FF80) begin
      n_fail++;
      $display("FAIL bload_rsp: got valid=%b rdata=%h want 1 ffffff80", bus.rsp_valid, bus.rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    logic [1:0]  sizes [3];
    logic [31:0] addrs [3];
    sizes[0] = 2'b00; addrs[0] = 32'h0000_3001;
    sizes[1] = 2'b11; addrs[1] = 32'h0000_2001;
    sizes[2] = 2'b10; addrs[2] = 32'h0000_5000;
    for (int k = 0; k < 3; k++) begin
      issue(1'b0, sizes[k], 1'b0, addrs[k], 32'h0);
      n_checks++;
      if ({bus.rsp_valid, bus.misalign_err, bus.timeout_err, bus.mem_req} !== 4'b1100 || bus.rsp_rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL misalign_rsp[%0d]: got v/me/te/req=%b rdata=%h want 1100 00000000",
                 k, {bus.rsp_valid, bus.misalign_err, bus.timeout_err, bus.mem_req}, bus.rsp_rdata);
      end
      @(negedge clk);
      n_checks++;
      if (bus.rsp_valid !== 1'b0 || bus.misalign_err !== 1'b0 || bus.req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL misalign_done[%0d]: got valid=%b me=%b ready=%b want 0 0 1",
                 k, bus.rsp_valid, bus.misalign_err, bus.req_ready);
      end
    end
  endtask

  task automatic test_timeout();
    int cnt;
    cnt = 0;
    issue(1'b0, 2'b00, 1'b0, 32'h0000_7000, 32'h0);
    bus.mem_rdata = 32'h1111_2222;
    for (int i = 0; i < 300 && bus.rsp_valid !== 1'b1; i++) begin
      if (bus.mem_req === 1'b1) cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || cnt != 256) begin
      n_fail++;
      $display("FAIL timeout_latency: got valid=%b access_cycles=%0d want 1 256", bus.rsp_valid, cnt);
    end
    n_checks++;
    if (bus.timeout_err !== 1'b1 || bus.misalign_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL timeout_rsp: got te=%b me=%b rdata=%h want 1 0 00000000", bus.timeout_err, bus.misalign_err, bus.rsp_rdata);
    end
    @(negedge clk);
    n_checks++;
    if (bus.timeout_err !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_done: got te=%b ready=%b want 0 1", bus.timeout_err, bus.req_ready);
    end
  endtask

  task automatic test_ack_at_256();
    issue(1'b0, 2'b00, 1'b0, 32'h0000_8000, 32'h0);
    repeat (255) @(negedge clk);
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ack256_still_access: got req=%b valid=%b want 1 0", bus.mem_req, bus.rsp_valid);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.timeout_err !== 1'b0 || bus.rsp_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL ack256_rsp: got valid=%b te=%b rdata=%h want 1 0 deadbeef", bus.rsp_valid, bus.timeout_err, bus.rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int seen;
    seen = 0;
    issue(1'b0, 2'b00, 1'b0, 32'h0000_9000, 32'h0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: got req=%b want 1", bus.mem_req);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_post: got req=%b valid=%b ready=%b busy=%b want 0 0 1 0",
               bus.mem_req, bus.rsp_valid, bus.req_ready, bus.busy);
    end
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1 || bus.busy === 1'b1) seen++;
    end
    bus.mem_ack = 1'b0;
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_rsp_idle_ack: got %0d busy/valid cycles want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 2'b00, 1'b0, 32'h0000_6000, 32'h1234_5678);
    n_checks++;
    if (bus.mem_be !== 4'b1111 || bus.mem_wdata !== 32'h1234_5678 || bus.mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_store: got be=%b wdata=%h we=%b want 1111 12345678 1", bus.mem_be, bus.mem_wdata, bus.mem_we);
    end
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_resp: got valid=%b ready=%b want 1 0", bus.rsp_valid, bus.req_ready);
    end
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: got %b want 1", bus.req_ready);
    end
    issue(1'b0, 2'b00, 1'b1, 32'h0000_6004, 32'h0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL b2b_load: got valid=%b rdata=%h want 1 cafef00d", bus.rsp_valid, bus.rsp_rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.mem_ack      = 1'b0;
    bus.mem_rdata    = 32'h0;
    test_reset();
    test_byte_store();
    test_halfword_load();
    test_byte_load();
    test_misaligned();
    test_timeout();
    test_ack_at_256();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_access_ctrl.md
DATA_MEM_ACCESS_CTRL -- requirements
Module: data_mem_access_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-003 The block SHALL have port req_valid, input, 1 bit, meaning a CPU load/store request is present.
REQ-004 The block SHALL have port req_ready, output, 1 bit, meaning the block can accept a request (high only in IDLE).
REQ-005 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-006 The block SHALL have port req_size, input, 2 bits: 2'b00 word, 2'b01 byte, 2'b11 halfword, 2'b10 illegal.
REQ-007 The block SHALL have port req_unsigned, input, 1 bit: 1 = zero-extend load data, 0 = sign-extend.
REQ-008 The block SHALL have port req_addr, input, 32 bits, the byte address.
REQ-009 The block SHALL have port req_wdata, input, 32 bits, the store data, already sized by the store-data mux.
REQ-010 The block SHALL have ports mem_req (out 1), mem_we (out 1), mem_addr (out 32), mem_be (out 4) and mem_wdata (out 32), forming the memory request.
REQ-011 The block SHALL have ports mem_ack (in 1) and mem_rdata (in 32), forming the memory completion.
REQ-012 The block SHALL have ports rsp_valid (out 1), rsp_rdata (out 32), misalign_err (out 1), timeout_err (out 1) and busy (out 1).

Function
REQ-013 The block SHALL implement FSM states IDLE, ACCESS and RESP; busy SHALL equal (state != IDLE).
REQ-014 In IDLE, when req_valid=1, the block SHALL latch we/size/unsigned/addr/wdata at the clock edge (req_ready=1 implies acceptance).
REQ-015 Misaligned or illegal requests SHALL cause a transition IDLE->RESP with no memory access:
  - halfword with addr[0]=1
  - word with addr[1:0]!=0
  - size 2'b10
REQ-016 All other accepted requests SHALL cause a transition IDLE->ACCESS.
REQ-017 In ACCESS, mem_req SHALL be 1 and mem_we SHALL equal the latched we.
REQ-018 In ACCESS, mem_addr SHALL be {addr[31:2],2'b00}.
REQ-019 In all states other than ACCESS, mem_req and mem_we SHALL be 0.
REQ-020 mem_be SHALL be:
  - byte: 4'b0001<<addr[1:0]
  - halfword: 4'b0011<<addr[1:0]
  - word: 4'b1111
REQ-021 mem_wdata SHALL be:
  - byte: {4{wdata[7:0]}}
  - halfword: {2{wdata[15:0]}}
  - word: wdata
REQ-022 In ACCESS, on mem_ack=1 the block SHALL register the response data and transition to RESP.
REQ-023 mem_ack SHALL be ignored in all states other than ACCESS.
REQ-024 For a load, response data SHALL be extracted as follows, extended per req_unsigned:
  - byte: the lane selected by addr[1:0]
  - halfword: the lane selected by addr[1]
  - word: mem_rdata unmodified
REQ-025 For a store, rsp_rdata SHALL be 0.
REQ-026 A 8-bit wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with mem_ack=0.
REQ-027 If the wait counter is 255 and mem_ack=0, the block SHALL go to RESP with timeout_err=1 and rsp_rdata=0.
REQ-028 An ack arriving in the same cycle as the timeout condition SHALL win; the response SHALL complete normally.
REQ-029 In RESP, rsp_valid SHALL be 1 for exactly one cycle, with rsp_rdata, misalign_err and timeout_err valid; the next state SHALL be IDLE.
REQ-030 misalign_err and timeout_err SHALL be 0 whenever rsp_valid=0.
REQ-031 Latency SHALL be:
  - aligned request, ack on first ACCESS cycle: rsp_valid 2 cycles after acceptance edge
  - misaligned request: rsp_valid 1 cycle after acceptance edge
REQ-032 A new request SHALL be accepted no earlier than the cycle after RESP.

Reset
REQ-033 On rst=1 at a clock edge, the state SHALL go to IDLE, and the wait counter and all latched fields SHALL clear to 0.
REQ-034 Outputs during and after reset SHALL be:
  - mem_req, mem_we, rsp_valid, misalign_err, timeout_err, busy: 0
  - mem_addr, mem_be, mem_wdata, rsp_rdata: 0
  - req_ready: 1
REQ-035 Reset asserted during ACCESS or RESP SHALL abort the transaction: mem_req deasserts the next cycle and no rsp_valid is produced.

Verification
REQ-036 The bench SHALL cover a byte store: addr 0x1003, wdata 0x000000A5 -> mem_be 4'b1000, mem_wdata 0xA5A5A5A5, mem_addr 0x1000; after ack, rsp_valid with rsp_rdata 0.
REQ-037 The bench SHALL cover a signed halfword load: addr 0x2002, mem_rdata 0x8001_1234 -> rsp_rdata 0xFFFF8001; the same load with unsigned=1 -> 0x00008001.
REQ-038 The bench SHALL cover a misaligned word: addr 0x3001 -> mem_req never asserted; rsp_valid 1 cycle after accept with misalign_err=1.
REQ-039 The bench SHALL cover a timeout: ack never asserted -> rsp_valid with timeout_err=1 after 256 ACCESS cycles.
REQ-040 The bench SHALL cover ack on the 256th ACCESS cycle -> normal response, timeout_err=0.
REQ-041 The bench SHALL cover rst in the 3rd ACCESS cycle -> mem_req=0 next cycle, no rsp_valid, req_ready=1.
